// File: rtl/cpu_pkg.sv
// Shared encodings for the PC/address arithmetic sequencer.
// Op codes, sequencer states and high-byte adjust codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_INC16 = 2'd0,
    OP_ADDU  = 2'd1,
    OP_ADDS  = 2'd2,
    OP_SUBU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ADJ_NONE = 2'd0,
    ADJ_INC  = 2'd1,
    ADJ_DEC  = 2'd2
  } adj_t;

endpackage

// File: rtl/cpu_alu_seq_adj.sv
// cpu_alu_seq_adj: carry/borrow detect on the low-byte ALU result and the high-byte adjust.
// Latency: combinational.
// Backpressure: none.
module cpu_alu_seq_adj
  import cpu_pkg::*;
(
  input  logic [1:0] op,
  input  logic [7:0] base_lo,
  input  logic [7:0] off,
  input  logic [7:0] alu_out,
  output logic [1:0] adj
);

  logic carry;

  always_comb begin
    adj   = ADJ_NONE;
    // The ALU has no carry output: an unsigned add carried iff the sum wrapped below A.
    carry = (alu_out < base_lo);
    case (op)
      OP_INC16: if (alu_out == 8'h00) adj = ADJ_INC;
      OP_ADDU:  if (carry) adj = ADJ_INC;
      OP_ADDS: begin
        if (carry && !off[7])      adj = ADJ_INC;
        else if (!carry && off[7]) adj = ADJ_DEC;
      end
      OP_SUBU:  if (base_lo < off) adj = ADJ_DEC;
      default:  adj = ADJ_NONE;
    endcase
  end

endmodule

// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: 16-bit PC/address arithmetic on the shared 8-bit ALU, low byte then high byte.
// Latency: done 2 edges after acceptance; 1 for non-crossing ops with CPU_ALU_SEQ_SKIP_HI_EN.
// Backpressure: req_ready only in IDLE; req_valid while busy is ignored and must be held.
module cpu_alu_seq
  import cpu_pkg::*;
#(
  parameter int SKIP_NONE_HI = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_base,
  input  logic [7:0]  req_off,
  output logic        alu_add,
  output logic        alu_sub,
  output logic        alu_pass_B,
  output logic        alu_inc_A,
  output logic        alu_inc_B,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  input  logic [7:0]  alu_out,
  output logic        done,
  output logic [15:0] result,
  output logic        page_cross
);

`ifdef CPU_ALU_SEQ_SKIP_HI_EN
  localparam bit skip_en = (SKIP_NONE_HI == 0);
`else
  localparam bit skip_en = 1'b0 & (SKIP_NONE_HI == 0);
`endif

  state_t      state_q;
  logic [1:0]  op_q;
  logic [15:0] base_q;
  logic [7:0]  off_q;
  logic [7:0]  res_lo_q;
  logic [1:0]  adj_q;
  logic [1:0]  adj;

  cpu_alu_seq_adj u_adj (
    .op      (op_q),
    .base_lo (base_q[7:0]),
    .off     (off_q),
    .alu_out (alu_out),
    .adj     (adj)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign alu_pass_B = 1'b0;
  assign alu_inc_B  = 1'b0;

  always_comb begin
    alu_add   = 1'b0;
    alu_sub   = 1'b0;
    alu_inc_A = 1'b0;
    alu_A     = 8'h00;
    alu_B     = 8'h00;
    case (state_q)
      ST_LO: begin
        alu_A = base_q[7:0];
        case (op_q)
          OP_INC16: alu_inc_A = 1'b1;
          OP_SUBU: begin
            alu_sub = 1'b1;
            alu_B   = off_q;
          end
          default: begin
            alu_add = 1'b1;
            alu_B   = off_q;
          end
        endcase
      end
      ST_HI: begin
        // With no adjust every control stays low and the ALU passes A through.
        alu_A = base_q[15:8];
        if (adj_q == ADJ_INC) begin
          alu_inc_A = 1'b1;
        end else if (adj_q == ADJ_DEC) begin
          alu_sub = 1'b1;
          alu_B   = 8'h01;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'b00;
      base_q     <= 16'h0000;
      off_q      <= 8'h00;
      res_lo_q   <= 8'h00;
      adj_q      <= ADJ_NONE;
      done       <= 1'b0;
      result     <= 16'h0000;
      page_cross <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            base_q  <= req_base;
            off_q   <= req_off;
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          res_lo_q <= alu_out;
          adj_q    <= adj;
          if (skip_en && (adj == ADJ_NONE)) begin
            result     <= {base_q[15:8], alu_out};
            page_cross <= 1'b0;
            done       <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            state_q <= ST_HI;
          end
        end
        ST_HI: begin
          result     <= {alu_out, res_lo_q};
          page_cross <= (adj_q != ADJ_NONE);
          done       <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Directed bench for cpu_alu_seq with a behavioural model of the shared 8-bit ALU.
module tb_cpu_alu_seq;
  import cpu_pkg::*;

`ifdef CPU_ALU_SEQ_SKIP_HI_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_base;
  logic [7:0]  req_off;
  logic        alu_add, alu_sub, alu_pass_B, alu_inc_A, alu_inc_B;
  logic [7:0]  alu_A, alu_B, alu_out;
  logic        done;
  logic [15:0] result;
  logic        page_cross;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_base   (req_base),
    .req_off    (req_off),
    .alu_add    (alu_add),
    .alu_sub    (alu_sub),
    .alu_pass_B (alu_pass_B),
    .alu_inc_A  (alu_inc_A),
    .alu_inc_B  (alu_inc_B),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_out    (alu_out),
    .done       (done),
    .result     (result),
    .page_cross (page_cross)
  );

  always_comb begin
    if (alu_add)         alu_out = alu_A + alu_B;
    else if (alu_sub)    alu_out = alu_A - alu_B;
    else if (alu_inc_A)  alu_out = alu_A + 8'd1;
    else if (alu_pass_B) alu_out = alu_B;
    else                 alu_out = alu_A;
  end

  wire [4:0] ctrl = {alu_add, alu_sub, alu_pass_B, alu_inc_A, alu_inc_B};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int lat_for(input logic pc);
    return (SKIP && !pc) ? 1 : 2;
  endfunction

  // Returns at 1 time unit after the accepting edge (sequencer in LO).
  task automatic issue(input logic [1:0] op, input logic [15:0] base, input logic [7:0] off);
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_base  = base;
    req_off   = off;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [15:0] exp_res, input logic exp_pc,
                             input int exp_lat);
    int lat = 99;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_pc"}, page_cross, exp_pc);
    check({tag, "_rdy"}, req_ready, 1);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("ctrl_onehot", $onehot0({alu_add, alu_sub, alu_inc_A}), 1);
      check("passb_incb_zero", {alu_pass_B, alu_inc_B}, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_done;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_base  = 16'h0000;
    req_off   = 8'h00;
    #2;
    check("rst_done", done, 0);
    check("rst_result", result, 16'h0000);
    check("rst_pc", page_cross, 0);
    check("rst_ready", req_ready, 1);
    check("rst_ctrl", ctrl, 5'b00000);
    check("rst_ops", {alu_A, alu_B}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // INC16 crossing a page
    issue(OP_INC16, 16'h12FF, 8'h00);
    check("inc_lo_ctrl", ctrl, 5'b00010);
    check("inc_lo_A", alu_A, 8'hFF);
    check("inc_lo_ready", req_ready, 0);
    @(posedge clk);
    #1;
    check("inc_hi_ctrl", ctrl, 5'b00010);
    check("inc_hi_A", alu_A, 8'h12);
    check("inc_hi_done", done, 0);
    expect_done("inc", 16'h1300, 1'b1, 1);

    issue(OP_ADDU, 16'h20F0, 8'h20);
    check("addu_lo_ctrl", ctrl, 5'b10000);
    check("addu_lo_ops", {alu_A, alu_B}, 16'hF020);
    @(posedge clk);
    #1;
    check("addu_hi_ctrl", ctrl, 5'b00010);
    check("addu_hi_A", alu_A, 8'h20);
    expect_done("addu_x", 16'h2110, 1'b1, 1);

    issue(OP_ADDU, 16'h2010, 8'h20);
    expect_done("addu_nx", 16'h2030, 1'b0, lat_for(1'b0));

    issue(OP_ADDS, 16'h3005, 8'hF0);
    check("adds_lo_ctrl", ctrl, 5'b10000);
    @(posedge clk);
    #1;
    check("adds_hi_ctrl", ctrl, 5'b01000);
    check("adds_hi_ops", {alu_A, alu_B}, 16'h3001);
    expect_done("adds_neg_x", 16'h2FF5, 1'b1, 1);

    issue(OP_ADDS, 16'h3010, 8'hF0);
    expect_done("adds_neg_nx", 16'h3000, 1'b0, lat_for(1'b0));

    issue(OP_ADDS, 16'h1234, 8'h10);
    expect_done("adds_pos_nx", 16'h1244, 1'b0, lat_for(1'b0));

    issue(OP_ADDS, 16'h12F0, 8'h20);
    expect_done("adds_pos_x", 16'h1310, 1'b1, 2);

    issue(OP_SUBU, 16'h4000, 8'h01);
    check("subu_lo_ctrl", ctrl, 5'b01000);
    check("subu_lo_ops", {alu_A, alu_B}, 16'h0001);
    expect_done("subu_x", 16'h3FFF, 1'b1, 2);

    issue(OP_INC16, 16'hFFFF, 8'h00);
    expect_done("inc_wrap", 16'h0000, 1'b1, 2);

    issue(OP_SUBU, 16'h0000, 8'h01);
    expect_done("subu_wrap", 16'hFFFF, 1'b1, 2);

    issue(OP_SUBU, 16'h5080, 8'h30);
    expect_done("subu_nx", 16'h5050, 1'b0, lat_for(1'b0));

    // Back-to-back with req_valid held high across both requests
    issue(OP_ADDU, 16'h2010, 8'h01);
    req_valid = 1'b1;
    req_op    = OP_INC16;
    req_base  = 16'h00FF;
    req_off   = 8'h00;
    check("b2b_busy_ready", req_ready, 0);
    lat = 99;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("b2b_first_lat", lat, lat_for(1'b0));
    check("b2b_first_res", result, 16'h2011);
    check("b2b_first_pc", page_cross, 0);
    check("b2b_first_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b_first_pulse", done, 0);
    check("b2b_second_busy", req_ready, 0);
    lat = 99;
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("b2b_spacing", lat, 3);
    check("b2b_second_res", result, 16'h0100);
    check("b2b_second_pc", page_cross, 1);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("b2b_no_extra_done", n_done, 0);

    // Asynchronous reset while the high byte is in flight
    issue(OP_ADDU, 16'h20F0, 8'h20);
    @(posedge clk);
    #1;
    check("rst_mid_in_hi", ctrl, 5'b00010);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", ctrl, 5'b00000);
    check("rst_mid_ops", {alu_A, alu_B}, 16'h0000);
    check("rst_mid_result", result, 16'h0000);
    check("rst_mid_pc", page_cross, 0);
    check("rst_mid_ready", req_ready, 1);
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("rst_mid_no_done", n_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_INC16, 16'h12FF, 8'h00);
    expect_done("after_rst", 16'h1300, 1'b1, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
